mod_check_sched: RTL and testbench
==================================

Name: mod_check_sched

Overview:
- Round-robin scheduler that shares one bit-serial modulo-residue engine between NUM_REQ requesters.
- Each requester offers a parallel DATA_W-bit word over a valid/ready handshake.
- The scheduler grants one requester, then shifts the word MSB-first into the residue engine, one bit per cycle.
- It returns the residue, a divisible flag and the requester id on a valid/ready response channel.
- It sits between parallel producers and the serial mod-N checking datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 8, width of each request word (>=1).
- MOD, 3, modulus (>=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  max(1,$clog2(NUM_REQ))  index of the requester that owns the result.
- rsp_residue  out  $clog2(MOD)  word mod MOD.
- rsp_divisible  out  1  high when rsp_residue == 0.
- busy  out  1  high in SHIFT or RESP.

Behaviour:
- Clocking and reset: single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_residue=0; rsp_divisible=0; busy=0.
  - Round-robin pointer last_id=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - req_ready is combinational and equals the one-hot grant.
  - Grant goes to the first i with req_valid[i], searching upward from last_id+1 and wrapping modulo NUM_REQ.
  - req_ready is 0 when no request is valid.
  - Acceptance is req_valid[i] && req_ready[i] at an edge. On acceptance: latch word into shift register, clear residue, bit_cnt=0, last_id=i, go to SHIFT.
  - Requesters hold valid and data until accepted; withdrawing before acceptance is legal, and arbitration is re-evaluated every IDLE cycle.
- SHIFT:
  - req_ready=0 on every edge.
  - Each edge applies residue <= (2*residue + msb) mod MOD, shifts left and increments bit_cnt.
  - The intermediate 2*residue+bit is held in $clog2(MOD)+1 bits; subtract MOD once if the value is >=MOD.
  - After exactly DATA_W SHIFT edges, go to RESP.
  - rsp_valid rises in the cycle following the DATA_W-th edge after acceptance.
- RESP:
  - rsp_valid=1; rsp_id, rsp_residue and rsp_divisible are held stable until rsp_valid && rsp_ready at an edge.
  - After that handshake, go to IDLE with rsp_valid=0.
  - No new grant is issued in RESP.
- Throughput: at most one word per DATA_W+2 cycles (IDLE, DATA_W SHIFT cycles, RESP).
- Boundary cases:
  - Word 0 gives residue 0 and divisible 1.
  - Simultaneous requests are served strictly round-robin, with no starvation.
  - A single persistent requester is re-granted every DATA_W+2 cycles.
  - rsp_ready held high while in IDLE or SHIFT has no effect.
- Reset mid-operation:
  - rst in SHIFT or RESP drops the in-flight word; no response is ever produced for it, and the requester does not re-offer it.
  - All state returns to reset values on that edge.

Decomposition:
- Package mod_check_pkg:
  - state enum (IDLE, SHIFT, RESP).
  - Width helper localparams: RES_W=$clog2(MOD), ID_W=max(1,$clog2(NUM_REQ)), CNT_W=$clog2(DATA_W+1).
- Sub-module mod_residue_serial (params MOD):
  - Ports: clk, rst, clr, en, din, residue.
  - Holds the residue register and the modular update; the scheduler drives clr on acceptance and en in SHIFT.
- Round-robin grant logic stays inline in mod_check_sched.

Test Plan (DATA_W=8, MOD=3 unless stated):
- req_valid=4'b0001, req_data[0]=8'h06, rsp_ready=1 -> req_ready=4'b0001 for one cycle; rsp_valid rises 8 edges after acceptance (DATA_W); rsp_id=0, residue=0, divisible=1.
- req1 only, data 8'h07 -> rsp_id=1, residue=1, divisible=0; busy high from acceptance through the response handshake.
- All four valid together with data 3,4,5,6, rsp_ready=1 -> grants in order 0,1,2,3; residues 0,1,2,0; consecutive acceptances exactly 10 cycles apart.
- rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready stays 0; IDLE on the cycle after rsp_ready=1.
- rst pulsed on the 4th SHIFT edge of a req2 word -> no rsp_valid for it, busy=0 next cycle; the next simultaneous request from req0 and req2 grants req0.
- Data 8'hFF and 8'h00 -> residue 0 / divisible 1 for both. MOD=5 instance with data 8'd23 -> residue 3, divisible 0.

Source files
------------

// File: rtl/mod_check_pkg.sv
// Shared types and width helpers for the round-robin mod-N residue checker.
// Each module derives its own RES_W / ID_W / CNT_W localparams from these helpers.
package mod_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

  function automatic int res_width(input int modulus);
    return $clog2(modulus);
  endfunction

  function automatic int id_width(input int num_req);
    return ($clog2(num_req) < 1) ? 1 : $clog2(num_req);
  endfunction

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/mod_residue_serial.sv
// Bit-serial residue engine: folds one MSB-first bit per enabled cycle into (value mod MOD).
module mod_residue_serial
  import mod_check_pkg::*;
#(
  parameter int MOD = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        din,
  output logic [res_width(MOD)-1:0]   residue
);

  localparam int RES_W = res_width(MOD);

  logic [RES_W:0]   dbl;
  logic [RES_W-1:0] res_nxt;

  // 2*r + b never reaches 2*MOD, so a single conditional subtract is a full reduction.
  always_comb begin
    dbl     = {residue, din};
    res_nxt = dbl[RES_W-1:0];
    if (dbl >= (RES_W+1)'(MOD)) res_nxt = RES_W'(dbl - (RES_W+1)'(MOD));
  end

  // NOTE: registers are updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) residue <= '0;
    else if (en)    residue <= res_nxt;
  end

endmodule

// File: rtl/mod_check_sched.sv
// Round-robin scheduler sharing one serial mod-N residue engine between NUM_REQ requesters.
module mod_check_sched
  import mod_check_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int MOD     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]  rsp_id,
  output logic [res_width(MOD)-1:0]     rsp_residue,
  output logic                          rsp_divisible,
  output logic                          busy
);

  localparam int RES_W = res_width(MOD);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(DATA_W);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_id, grant_id, rsp_id_q;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vld, accept, shift_en, last_bit;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [RES_W-1:0]   residue;

  // Search upward from the requester after the last winner, wrapping round.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld && req_valid[(int'(last_id) + k) % NUM_REQ]) begin
        grant_vld                              = 1'b1;
        grant_id                               = ID_W'((int'(last_id) + k) % NUM_REQ);
        grant[(int'(last_id) + k) % NUM_REQ]   = 1'b1;
      end
    end
  end

  assign accept   = (state == IDLE) && grant_vld;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = 1'b0;
    rsp_divisible = 1'b0;
    busy          = 1'b0;
    shift_en      = 1'b0;
    case (state)
      IDLE:  req_ready = grant;
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      RESP: begin
        busy          = 1'b1;
        rsp_valid     = 1'b1;
        rsp_divisible = (residue == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id  <= ID_W'(NUM_REQ - 1);
      rsp_id_q <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
    end else if (accept) begin
      shreg    <= req_data[grant_id*DATA_W +: DATA_W];
      bit_cnt  <= '0;
      last_id  <= grant_id;
      rsp_id_q <= grant_id;
    end else if (shift_en) begin
      shreg    <= shreg << 1;
      bit_cnt  <= bit_cnt + CNT_W'(1);
    end
  end

  mod_residue_serial #(.MOD(MOD)) u_res (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (shift_en),
    .din     (shreg[DATA_W-1]),
    .residue (residue)
  );

  assign rsp_id      = rsp_id_q;
  assign rsp_residue = residue;

endmodule

// File: tb/tb_mod_check_sched.sv
// Self-checking bench: cycle-level reference model of the scheduler plus directed scenarios.
module tb_mod_check_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int MOD     = 3;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] res;
    logic       dv;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready, rsp_divisible, busy;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_residue;

  logic        rst5;
  logic [3:0]  req_valid5;
  logic [31:0] req_data5;
  logic [3:0]  req_ready5;
  logic        rsp_valid5, rsp_ready5, rsp_divisible5, busy5;
  logic [1:0]  rsp_id5;
  logic [2:0]  rsp_residue5;

  always #5 clk = ~clk;

  mod_check_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_residue(rsp_residue), .rsp_divisible(rsp_divisible),
    .busy(busy)
  );

  mod_check_sched #(.NUM_REQ(4), .DATA_W(8), .MOD(5)) dut5 (
    .clk(clk), .rst(rst5), .req_valid(req_valid5), .req_data(req_data5),
    .req_ready(req_ready5), .rsp_valid(rsp_valid5), .rsp_ready(rsp_ready5),
    .rsp_id(rsp_id5), .rsp_residue(rsp_residue5), .rsp_divisible(rsp_divisible5),
    .busy(busy5)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    return (g < 0) ? 4'b0 : 4'(1 << g);
  endfunction

  // Reference model: busy after a grant, response window once DATA_W shift cycles have elapsed.
  bit   started = 1'b0;
  bit   m_busy;
  int   m_last, m_cnt, m_id, m_word;
  int   cyc = 0;
  int   acc_ids[$];
  int   acc_cyc[$];
  int   rise_cyc[$];
  rsp_t rsp_q[$];
  int   rdy_cycles = 0;
  bit   prev_v = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
    if (rst) begin
      m_busy <= 1'b0;
      m_last <= NUM_REQ - 1;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (rr_pick(m_last, req_valid) >= 0) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_id   <= rr_pick(m_last, req_valid);
        m_word <= int'(req_data[rr_pick(m_last, req_valid)*DATA_W +: DATA_W]);
        m_last <= rr_pick(m_last, req_valid);
        acc_ids.push_back(rr_pick(m_last, req_valid));
        acc_cyc.push_back(cyc + 1);
      end
    end else if (m_cnt < DATA_W) begin
      m_cnt <= m_cnt + 1;
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", busy, m_busy);
      check("rsp_valid", rsp_valid, m_busy && (m_cnt == DATA_W));
      check("req_ready", req_ready, m_busy ? 4'b0 : onehot(rr_pick(m_last, req_valid)));
      if (m_busy && (m_cnt == DATA_W)) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_residue", rsp_residue, m_word % MOD);
        check("rsp_divisible", rsp_divisible, (m_word % MOD) == 0);
      end
      if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_id, rsp_residue, rsp_divisible});
      if (|req_ready) rdy_cycles++;
      if (rsp_valid && !prev_v) rise_cyc.push_back(cyc);
      prev_v = rsp_valid;
    end
  end

  // Offer words, drop each requester's valid after its acceptance, wait until idle again.
  task automatic serve(input logic [3:0] mask, input logic [31:0] words, input int budget);
    logic [3:0] acc;
    int         n;
    bit         done;
    #1;
    req_data  = words;
    req_valid = mask;
    n         = 0;
    done      = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (req_valid == 4'b0 && !busy && !rsp_valid) done = 1'b1;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      n++;
    end
    check("serve_done", done, 1);
  endtask

  task automatic expect_rsp(input string name, input int id, input int res, input int dv);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      check({name, "_present"}, 0, 1);
    end else begin
      r = rsp_q.pop_front();
      check({name, "_id"}, r.id, id);
      check({name, "_res"}, r.res, res);
      check({name, "_div"}, r.dv, dv);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  n_a, n_r, base, n;
    bit  got, acc5;

    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    rst5 = 1'b1; req_valid5 = '0; req_data5 = '0; rsp_ready5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst5 = 1'b0;

    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_residue", rsp_residue, 0);
    check("rst_rsp_divisible", rsp_divisible, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // Single requester 0, word 6.
    n_a = acc_cyc.size(); n_r = rise_cyc.size(); base = rdy_cycles;
    serve(4'b0001, 32'h0000_0006, 40);
    check("t1_ready_cycles", rdy_cycles - base, 1);
    if (acc_cyc.size() > n_a && rise_cyc.size() > n_r)
      check("t1_latency", rise_cyc[n_r] - acc_cyc[n_a], 8);
    else
      check("t1_events", (acc_cyc.size() - n_a) + (rise_cyc.size() - n_r), 2);
    expect_rsp("t1", 0, 0, 1);

    // Requester 1 only, word 7.
    serve(4'b0010, 32'h0000_0700, 40);
    expect_rsp("t2", 1, 1, 0);

    // All four at once after reset: strict round-robin, one word per 10 cycles.
    pulse_reset();
    n_a = acc_ids.size();
    serve(4'b1111, 32'h0605_0403, 80);
    if (acc_ids.size() >= n_a + 4) begin
      for (int i = 0; i < 4; i++) check("t3_grant_order", acc_ids[n_a+i], i);
      for (int i = 1; i < 4; i++) check("t3_spacing", acc_cyc[n_a+i] - acc_cyc[n_a+i-1], 10);
    end else begin
      check("t3_accepts", acc_ids.size() - n_a, 4);
    end
    expect_rsp("t3_r0", 0, 0, 1);
    expect_rsp("t3_r1", 1, 1, 0);
    expect_rsp("t3_r2", 2, 2, 0);
    expect_rsp("t3_r3", 3, 0, 1);

    // Back-pressure in RESP while another requester waits.
    rsp_ready = 1'b0;
    req_data  = 32'h090A_0000;
    req_valid = 4'b0100;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = req_ready[2];
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_accept", got, 1);
    req_valid = 4'b1000;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = rsp_valid;
      n++;
    end
    check("t4_resp_seen", got, 1);
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_valid", rsp_valid, 1);
      check("t4_stall_ready", req_ready, 0);
      check("t4_stall_residue", rsp_residue, 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_idle_busy", busy, 0);
    check("t4_idle_valid", rsp_valid, 0);
    check("t4_idle_grant", req_ready, 4'b1000);
    serve(4'b1000, 32'h090A_0000, 40);
    expect_rsp("t4_r2", 2, 1, 0);
    expect_rsp("t4_r3", 3, 0, 1);

    // Reset on the 4th shift edge of a requester-2 word drops it entirely.
    req_data  = 32'h0055_0000;
    req_valid = 4'b0100;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = req_ready[2];
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_accept", got, 1);
    req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_busy_after_rst", busy, 0);
    check("t5_valid_after_rst", rsp_valid, 0);
    n_r = rise_cyc.size();
    repeat (15) @(negedge clk);
    check("t5_no_rsp", rise_cyc.size() - n_r, 0);
    check("t5_no_handshake", rsp_q.size(), 0);
    @(posedge clk);
    n_a = acc_ids.size();
    serve(4'b0101, 32'h0010_000B, 60);
    if (acc_ids.size() >= n_a + 2) begin
      check("t5_first_grant", acc_ids[n_a], 0);
      check("t5_second_grant", acc_ids[n_a+1], 2);
    end else begin
      check("t5_accepts", acc_ids.size() - n_a, 2);
    end
    expect_rsp("t5_r0", 0, 2, 0);
    expect_rsp("t5_r2", 2, 1, 0);

    // All-ones and all-zeros words.
    serve(4'b0001, 32'h0000_00FF, 40);
    expect_rsp("t6_ff", 0, 0, 1);
    serve(4'b0001, 32'h0000_0000, 40);
    expect_rsp("t6_00", 0, 0, 1);

    // Second instance with modulus 5, word 23.
    req_data5  = 32'd23;
    req_valid5 = 4'b0001;
    got = 1'b0; acc5 = 1'b0; n = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      if (rsp_valid5) begin
        got = 1'b1;
      end else begin
        if (req_ready5[0]) acc5 = 1'b1;
        @(posedge clk);
        #1;
        if (acc5) req_valid5 = '0;
      end
      n++;
    end
    check("m5_resp_seen", got, 1);
    check("m5_id", rsp_id5, 0);
    check("m5_residue", rsp_residue5, 3);
    check("m5_divisible", rsp_divisible5, 0);
    check("m5_busy", busy5, 1);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
